// File: rtl/wash_cycle_sequencer.sv
// Washing-machine programme sequencer: fill / wash / drain / rinse / spin with
// per-mode timing, level-sensor timeouts, pause, and a door interlock.
module wash_cycle_sequencer #(
  parameter int CW            = 8,
  parameter int WASH_QUICK    = 4,
  parameter int WASH_NORMAL   = 8,
  parameter int WASH_HEAVY    = 12,
  parameter int RINSE_CYC     = 4,
  parameter int SPIN_CYC      = 6,
  parameter int LEVEL_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       door_closed,
  input  logic       level_full,
  input  logic       level_empty,
  input  logic       pause,
  input  logic       fault_clr,
  output logic       valve_in,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       pump,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [CW-1:0] L_LEVEL  = CW'(LEVEL_TIMEOUT - 1);
  localparam logic [CW-1:0] L_QUICK  = CW'(WASH_QUICK - 1);
  localparam logic [CW-1:0] L_NORMAL = CW'(WASH_NORMAL - 1);
  localparam logic [CW-1:0] L_HEAVY  = CW'(WASH_HEAVY - 1);
  localparam logic [CW-1:0] L_RINSE  = CW'(RINSE_CYC - 1);
  localparam logic [CW-1:0] L_SPIN   = CW'(SPIN_CYC - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    rinse_left_q;
  logic          rinse_flag_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] wash_load;

  always_comb begin
    case (mode_q)
      2'd1:    wash_load = L_NORMAL;
      2'd2:    wash_load = L_HEAVY;
      default: wash_load = L_QUICK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rinse_left_q <= '0;
      rinse_flag_q <= 1'b0;
      mode_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && door_closed) begin
            mode_q       <= mode;
            rinse_flag_q <= 1'b0;
            rinse_left_q <= (mode == 2'd2) ? 2'd2 : (mode == 2'd3) ? 2'd0 : 2'd1;
            cnt_q        <= L_LEVEL;
            state_q      <= (mode == 2'd3) ? S_DRAIN : S_FILL;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_FAULT: if (fault_clr) state_q <= S_IDLE;
        default: begin
          // Door interlock outranks pause and every normal exit.
          if (!door_closed) begin
            state_q <= S_FAULT;
          end else if (!pause) begin
            case (state_q)
              S_FILL: begin
                if (level_full) begin
                  state_q <= rinse_flag_q ? S_RINSE : S_WASH;
                  cnt_q   <= rinse_flag_q ? L_RINSE : wash_load;
                end else if (cnt_q == '0) begin
                  state_q <= S_FAULT;
                end else begin
                  cnt_q <= cnt_q - 1'b1;
                end
              end
              S_WASH: begin
                if (cnt_q == '0) begin
                  state_q <= S_DRAIN;
                  cnt_q   <= L_LEVEL;
                end else begin
                  cnt_q <= cnt_q - 1'b1;
                end
              end
              S_RINSE: begin
                if (cnt_q == '0) begin
                  state_q      <= S_DRAIN;
                  cnt_q        <= L_LEVEL;
                  rinse_left_q <= rinse_left_q - 1'b1;
                end else begin
                  cnt_q <= cnt_q - 1'b1;
                end
              end
              S_DRAIN: begin
                if (level_empty) begin
                  if (rinse_left_q != '0) begin
                    state_q      <= S_FILL;
                    cnt_q        <= L_LEVEL;
                    rinse_flag_q <= 1'b1;
                  end else begin
                    state_q <= S_SPIN;
                    cnt_q   <= L_SPIN;
                  end
                end else if (cnt_q == '0) begin
                  state_q <= S_FAULT;
                end else begin
                  cnt_q <= cnt_q - 1'b1;
                end
              end
              S_SPIN: begin
                if (cnt_q == '0) state_q <= S_DONE;
                else             cnt_q   <= cnt_q - 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    valve_in   = 1'b0;
    motor_wash = 1'b0;
    motor_spin = 1'b0;
    pump       = 1'b0;
    door_lock  = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FILL: begin
        valve_in  = !pause;
        door_lock = 1'b1;
      end
      S_WASH, S_RINSE: begin
        motor_wash = !pause;
        door_lock  = 1'b1;
      end
      S_DRAIN: begin
        pump      = !pause;
        door_lock = 1'b1;
      end
      S_SPIN: begin
        motor_spin = !pause;
        pump       = !pause;
        door_lock  = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_FAULT: begin
        fault = 1'b1;
        pump  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign phase = state_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer: phase timing per mode, timeouts,
// pause, door interlock and asynchronous reset.
module tb_wash_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       door_closed;
  logic       level_full;
  logic       level_empty;
  logic       pause;
  logic       fault_clr;
  logic       valve_in, motor_wash, motor_spin, pump, door_lock, busy, done, fault;
  logic [2:0] phase;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;
  int rinses, fills, wash_n, spin_n, nseq, active;
  logic [2:0] prev;
  logic [2:0] seq [0:7];
  logic       valve_seen;

  wash_cycle_sequencer #(
    .CW(8), .WASH_QUICK(4), .WASH_NORMAL(8), .WASH_HEAVY(12),
    .RINSE_CYC(4), .SPIN_CYC(6), .LEVEL_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .door_closed(door_closed),
    .level_full(level_full), .level_empty(level_empty), .pause(pause),
    .fault_clr(fault_clr), .valve_in(valve_in), .motor_wash(motor_wash),
    .motor_spin(motor_spin), .pump(pump), .door_lock(door_lock), .busy(busy),
    .done(done), .fault(fault), .phase(phase)
  );

  always #5 clk = ~clk;

  // {valve_in, motor_wash, motor_spin, pump, door_lock, busy, done, fault}
  assign outs = {valve_in, motor_wash, motor_spin, pump, door_lock, busy, done, fault};

  function automatic logic [7:0] exp_outs(input logic [2:0] p);
    case (p)
      3'd1:       return 8'b1000_1100;
      3'd2, 3'd4: return 8'b0100_1100;
      3'd3:       return 8'b0001_1100;
      3'd5:       return 8'b0011_1100;
      3'd6:       return 8'b0000_0110;
      3'd7:       return 8'b0001_0101;
      default:    return 8'b0000_0000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n cycles in phase p, each sampled one tick later, outputs checked too
  task automatic run(input string tag, input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      chk(tag, {29'd0, phase}, {29'd0, p});
      chk({tag, "_outs"}, {24'd0, outs}, {24'd0, exp_outs(p)});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; door_closed = 1'b1;
    level_full = 1'b0; level_empty = 1'b0; pause = 1'b0; fault_clr = 1'b0;
    tick; tick;
    chk("reset_phase", {29'd0, phase}, 32'd0);
    chk("reset_outs", {24'd0, outs}, 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_no_start", {29'd0, phase}, 32'd0);

    // Mode 0 full programme
    mode = 2'd0; start = 1'b1;
    run("m0_fill", 3'd1, 4);
    start = 1'b0; mode = 2'd2; level_full = 1'b1;
    run("m0_wash", 3'd2, 4);
    run("m0_drain1", 3'd3, 3);
    level_empty = 1'b1;
    run("m0_fill2", 3'd1, 1);
    level_empty = 1'b0;
    run("m0_rinse", 3'd4, 4);
    run("m0_drain2", 3'd3, 3);
    level_empty = 1'b1;
    run("m0_spin", 3'd5, 6);
    level_empty = 1'b0;
    run("m0_done", 3'd6, 1);
    run("m0_idle", 3'd0, 2);

    // Asynchronous reset mid-WASH
    mode = 2'd1; start = 1'b1; level_full = 1'b1;
    tick; start = 1'b0;
    tick; tick;
    chk("rst_pre_wash", {29'd0, phase}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", {24'd0, outs}, 32'd0);
    chk("rst_async_phase", {29'd0, phase}, 32'd0);
    tick;
    rst = 1'b0;
    run("rst_after_idle", 3'd0, 2);

    // Mode 2: two rinses before spin
    mode = 2'd2; start = 1'b1; level_full = 1'b1; level_empty = 1'b1;
    tick; start = 1'b0;
    rinses = 0; fills = 0; wash_n = 0; prev = 3'd0;
    for (int i = 0; i < 100 && phase != 3'd6; i++) begin
      if (phase == 3'd4 && prev != 3'd4) rinses++;
      if (phase == 3'd1 && prev != 3'd1) fills++;
      if (phase == 3'd2) wash_n++;
      prev = phase;
      tick;
    end
    chk("m2_reach_done", {29'd0, phase}, 32'd6);
    chk("m2_rinses", rinses, 32'd2);
    chk("m2_fills", fills, 32'd3);
    chk("m2_wash_len", wash_n, 32'd12);
    chk("m2_pre_done", {29'd0, prev}, 32'd5);
    run("m2_idle", 3'd0, 1);

    // Mode 3: drain -> spin -> done, inlet never opened
    mode = 2'd3; start = 1'b1; level_full = 1'b0; level_empty = 1'b1;
    tick; start = 1'b0;
    nseq = 0; spin_n = 0; valve_seen = 1'b0; prev = 3'd0;
    for (int i = 0; i < 100 && phase != 3'd6; i++) begin
      if (phase != prev && nseq < 8) begin
        seq[nseq] = phase;
        nseq++;
      end
      if (phase == 3'd5) spin_n++;
      valve_seen = valve_seen | valve_in;
      prev = phase;
      tick;
    end
    chk("m3_reach_done", {29'd0, phase}, 32'd6);
    chk("m3_nseq", nseq, 32'd2);
    chk("m3_first", {29'd0, seq[0]}, 32'd3);
    chk("m3_second", {29'd0, seq[1]}, 32'd5);
    chk("m3_spin_len", spin_n, 32'd6);
    chk("m3_valve", {31'd0, valve_seen}, 32'd0);
    run("m3_idle", 3'd0, 1);

    // Fill timeout
    mode = 2'd0; start = 1'b1; level_full = 1'b0; level_empty = 1'b0;
    run("to_fill", 3'd1, 1);
    start = 1'b0;
    run("to_fill", 3'd1, 14);
    run("to_fault", 3'd7, 2);
    fault_clr = 1'b1;
    run("to_clr", 3'd0, 1);
    fault_clr = 1'b0;

    // Pause in WASH, mode 1
    mode = 2'd1; start = 1'b1; level_full = 1'b1;
    run("pz_fill", 3'd1, 1);
    start = 1'b0;
    run("pz_wash_pre", 3'd2, 3);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("pz_phase", {29'd0, phase}, 32'd2);
      chk("pz_outs", {24'd0, outs}, 32'h0C);
    end
    pause = 1'b0;
    active = 3;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (phase != 3'd2) break;
      active++;
    end
    chk("pz_wash_total", active, 32'd8);
    chk("pz_next", {29'd0, phase}, 32'd3);

    // Door open during SPIN
    level_empty = 1'b1;
    for (int i = 0; i < 50 && phase != 3'd5; i++) tick;
    chk("door_in_spin", {29'd0, phase}, 32'd5);
    door_closed = 1'b0;
    run("door_fault", 3'd7, 1);
    fault_clr = 1'b1;
    run("door_clr", 3'd0, 1);
    fault_clr = 1'b0;

    // start with door open is ignored
    start = 1'b1;
    run("door_open_idle", 3'd0, 3);
    start = 1'b0;
    door_closed = 1'b1;
    run("final_idle", 3'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
Programme sequencer for the washing-machine datapath. It latches a 2-bit wash mode on start and steps the actuators through fill, wash, drain, rinse and spin phases with per-mode timed durations. It waits on water-level sensors with timeouts, supports pause, and locks the door for the whole run. The valve, motor and pump outputs drive the machine directly; a phase code is exported for display and the bench monitor.

Parameters:
CW, 8, width of the phase countdown counter
WASH_QUICK, 4, WASH-phase cycles in mode 0
WASH_NORMAL, 8, WASH-phase cycles in mode 1
WASH_HEAVY, 12, WASH-phase cycles in mode 2
RINSE_CYC, 4, RINSE agitate cycles per rinse
SPIN_CYC, 6, SPIN-phase cycles
LEVEL_TIMEOUT, 15, max cycles in FILL or DRAIN before a fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  level; sampled in IDLE only
mode  in  2  0 quick, 1 normal, 2 heavy, 3 spin-only; latched on start
door_closed  in  1  door sensor, 1 = closed
level_full  in  1  drum water at full level
level_empty  in  1  drum empty
pause  in  1  freezes the current phase while high
fault_clr  in  1  leaves FAULT
valve_in  out  1  inlet valve
motor_wash  out  1  agitate motor
motor_spin  out  1  spin motor
pump  out  1  drain pump
door_lock  out  1  door lock solenoid
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
fault  out  1  high in FAULT
phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 RINSE, 5 SPIN, 6 DONE, 7 FAULT

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, rinse_left 0, rinse_flag 0, mode register 0, and every output 0.
- Moore outputs decoded from the registered state:
  - FILL: valve_in, door_lock.
  - WASH and RINSE: motor_wash, door_lock.
  - DRAIN: pump, door_lock.
  - SPIN: motor_spin, pump, door_lock.
  - DONE: done.
  - FAULT: fault and pump; door_lock stays 0.
- IDLE exit requires start=1 and door_closed=1, evaluated at a clock edge.
  - On that edge: latch mode and load rinse_left (mode 0: 1, mode 1: 1, mode 2: 2, mode 3: 0).
  - Modes 0-2 go to FILL; mode 3 goes to DRAIN.
  - start with the door open is ignored; the block stays in IDLE.
- On entry to every timed state (FILL, DRAIN, WASH, RINSE, SPIN) the counter loads the duration minus 1. The state exits on the edge where counter==0, so a duration of N gives exactly N cycles in the state.
- FILL:
  - level_full=1 moves to RINSE if rinse_flag=1, otherwise to WASH.
  - The counter reaching 0 with level_full=0 moves to FAULT.
- WASH moves to DRAIN after WASH_x cycles, chosen by the latched mode.
- RINSE moves to DRAIN after RINSE_CYC cycles and decrements rinse_left.
- DRAIN:
  - level_empty=1 goes to FILL with rinse_flag set if rinse_left>0, otherwise to SPIN.
  - Timeout moves to FAULT.
  - In mode 3, DRAIN goes to SPIN once empty.
- SPIN moves to DONE after SPIN_CYC cycles. DONE lasts one cycle, then IDLE.
- pause=1 in FILL, WASH, RINSE, DRAIN or SPIN:
  - Counter held and no transition.
  - valve_in, motor_wash, motor_spin and pump forced to 0; door_lock held at 1.
  - Sensor-driven exits are also blocked.
  - pause is ignored in IDLE, DONE and FAULT.
- door_closed=0 in any busy state other than DONE or FAULT moves to FAULT on the next edge. This takes priority over pause and over normal exits.
- FAULT holds until fault_clr=1, then returns to IDLE on the next edge; rst also clears it.
- mode and start changes mid-run have no effect.
- rst asserted mid-run takes effect immediately; all actuators drop to 0 asynchronously.

Test Plan:
- Reset: assert rst mid-WASH -> all outputs 0 at once and phase=0; after release the block idles with start=0.
- Mode 0 with door closed:
  - Stimulus: start; level_full asserted 3 cycles after FILL entry; level_empty asserted 2 cycles after each DRAIN entry.
  - Required phase sequence: 1 for 4 cycles, 2 for 4, 3 for 3, 1, 4 for 4, 3, 5 for 6, 6 for 1 cycle with done=1, then 0.
- Mode 2: two RINSE phases must occur before SPIN. Mode 3: phases 3 -> 5 -> 6 only, with valve_in never high.
- Fill timeout: level_full held 0 -> phase=7 after exactly 15 FILL cycles, fault=1, pump=1. fault_clr -> IDLE next edge.
- Pause: pause high for 5 cycles in WASH (mode 1) -> motor_wash=0 and door_lock=1 during pause; WASH totals 8 active cycles.
- Door open during SPIN -> phase=7 next edge. start with door_closed=0 in IDLE -> stays phase 0.
